// File: rtl/sd_pkg.sv
// sd_pkg: shared types and constants for the SD command engine.
// FSM states, response-type codes, error bit positions, CMD41 index.
package sd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_SEND_REL,
    S_WAIT_RESP,
    S_RESP_ACK,
    S_RETRY,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [1:0] RESP_NONE  = 2'd0;
  localparam logic [1:0] RESP_SHORT = 2'd1;
  localparam logic [1:0] RESP_LONG  = 2'd2;
  localparam logic [1:0] RESP_BUSY  = 2'd3;

  localparam int ERR_TMO = 0;
  localparam int ERR_IDX = 1;
  localparam int ERR_CRC = 2;

  localparam int CMD41 = 41;

  function automatic logic is_short(input logic [1:0] rt);
    return (rt == RESP_SHORT) || (rt == RESP_BUSY);
  endfunction

endpackage

// File: rtl/sd_cmd_engine_if.sv
// sd_cmd_engine_if: four-phase req/ack link to the serial CMD host.
// master = command engine, slave = serial host / PHY.
interface sd_cmd_engine_if #(
  parameter int IDX_W  = 6,
  parameter int ARG_W  = 32,
  parameter int RESP_W = 128
);
  localparam int CMD_W = 2 + IDX_W + ARG_W;

  logic              req_out;
  logic [CMD_W-1:0]  cmd_out;
  logic              ack_in;
  logic              req_in;
  logic [RESP_W-1:0] cmd_in;
  logic              crc_err_in;
  logic              ack_out;

  modport master (
    output req_out, cmd_out, ack_out,
    input  ack_in, req_in, cmd_in, crc_err_in
  );

  modport slave (
    input  req_out, cmd_out, ack_out,
    output ack_in, req_in, cmd_in, crc_err_in
  );

endinterface

// File: rtl/sd_cmd_timeout.sv
// sd_cmd_timeout: wait-cycle counter for the ack and response waits.
// Held at zero while clear; expire flags the last allowed cycle.
module sd_cmd_timeout #(
  parameter int TMO_W   = 16,
  parameter int TMO_CYC = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [TMO_W-1:0] tmo_cnt;

  // Count cycles spent waiting; saturate instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      tmo_cnt <= '0;
    end else if (enable && (tmo_cnt != '1)) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign expire = enable &&
    (tmo_cnt == TMO_W'(TMO_CYC - 1));

endmodule

// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine: frames an SD command, hands it to the serial host,
// collects the response with timeout/retry and kicks the data path.
module sd_cmd_engine
  import sd_pkg::*;
#(
  parameter int IDX_W     = 6,
  parameter int ARG_W     = 32,
  parameter int RESP_W    = 128,
  parameter int TMO_W     = 16,
  parameter int TMO_CYC   = 64,
  parameter int MAX_RETRY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic [IDX_W-1:0]  cmd_index,
  input  logic [ARG_W-1:0]  argument_reg,
  input  logic [1:0]        resp_type,
  input  logic              data_read,
  input  logic              data_write,
  sd_cmd_engine_if.master   phy,
  output logic [RESP_W-1:0] resp_out,
  output logic              idle_out,
  output logic              done_out,
  output logic [2:0]        err_out,
  output logic              data_rd_start,
  output logic              data_wr_start
);

  localparam int RC_W =
    (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t          state;
  logic [1:0]      rtype_q;
  logic            rd_q;
  logic            wr_q;
  logic            crc_q;
  logic [1:0]      cause;
  logic [RC_W-1:0] retry_cnt;
  logic            tmo_en;
  logic            tmo_exp;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] resp_idx;
  logic            idx_bad;

  assign idx_q    = phy.cmd_out[ARG_W +: IDX_W];
  assign resp_idx = resp_out[ARG_W +: IDX_W];

  // CMD41 (OCR) and long responses carry no echoed index.
  assign idx_bad = is_short(rtype_q) &&
    (idx_q != IDX_W'(CMD41)) &&
    (resp_idx != idx_q);

  assign tmo_en = (state == S_SEND) ||
    (state == S_WAIT_RESP);

  sd_cmd_timeout #(
    .TMO_W  (TMO_W),
    .TMO_CYC(TMO_CYC)
  ) u_tmo (
    .clock (clock),
    .reset (reset),
    .clear (!tmo_en),
    .enable(tmo_en),
    .expire(tmo_exp)
  );

  // Command FSM; every output is a register set on state entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      phy.req_out   <= 1'b0;
      phy.cmd_out   <= '0;
      phy.ack_out   <= 1'b0;
      resp_out      <= '0;
      idle_out      <= 1'b1;
      done_out      <= 1'b0;
      err_out       <= '0;
      data_rd_start <= 1'b0;
      data_wr_start <= 1'b0;
      rtype_q       <= RESP_NONE;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      crc_q         <= 1'b0;
      cause         <= '0;
      retry_cnt     <= '0;
    end else begin
      done_out      <= 1'b0;
      data_rd_start <= 1'b0;
      data_wr_start <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_start) begin
            phy.cmd_out <= {1'b0, 1'b1,
              cmd_index, argument_reg};
            rtype_q     <= resp_type;
            rd_q        <= data_read;
            wr_q        <= data_write;
            err_out     <= '0;
            resp_out    <= '0;
            retry_cnt   <= '0;
            phy.req_out <= 1'b1;
            idle_out    <= 1'b0;
            state       <= S_SEND;
          end
        end
        S_SEND: begin
          if (phy.ack_in) begin
            phy.req_out <= 1'b0;
            state       <= S_SEND_REL;
          end else if (tmo_exp) begin
            phy.req_out      <= 1'b0;
            err_out[ERR_TMO] <= 1'b1;
            done_out         <= 1'b1;
            state            <= S_FAIL;
          end
        end
        S_SEND_REL: begin
          if (!phy.ack_in) begin
            if (rtype_q == RESP_NONE) begin
              done_out      <= 1'b1;
              data_rd_start <= rd_q;
              data_wr_start <= wr_q;
              state         <= S_DONE;
            end else begin
              state <= S_WAIT_RESP;
            end
          end
        end
        S_WAIT_RESP: begin
          if (phy.req_in) begin
            resp_out    <= phy.cmd_in;
            crc_q       <= phy.crc_err_in;
            phy.ack_out <= 1'b1;
            state       <= S_RESP_ACK;
          end else if (tmo_exp) begin
            cause <= 2'(ERR_TMO);
            state <= S_RETRY;
          end
        end
        S_RESP_ACK: begin
          if (!phy.req_in) begin
            phy.ack_out <= 1'b0;
            if (crc_q) begin
              cause <= 2'(ERR_CRC);
              state <= S_RETRY;
            end else if (idx_bad) begin
              err_out[ERR_IDX] <= 1'b1;
              done_out         <= 1'b1;
              state            <= S_FAIL;
            end else begin
              done_out      <= 1'b1;
              data_rd_start <= rd_q;
              data_wr_start <= wr_q;
              state         <= S_DONE;
            end
          end
        end
        S_RETRY: begin
          if (retry_cnt < RC_W'(MAX_RETRY)) begin
            retry_cnt   <= retry_cnt + RC_W'(1);
            phy.req_out <= 1'b1;
            state       <= S_SEND;
          end else begin
            err_out[cause] <= 1'b1;
            done_out       <= 1'b1;
            state          <= S_FAIL;
          end
        end
        S_DONE, S_FAIL: begin
          idle_out <= 1'b1;
          state    <= S_IDLE;
        end
        default: begin
          idle_out <= 1'b1;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// tb_sd_cmd_engine: directed and randomized checks of sd_cmd_engine
// against a behavioural outcome model of the command/retry rules.
module tb_sd_cmd_engine;
  import sd_pkg::*;

  localparam int IDX_W     = 6;
  localparam int ARG_W     = 32;
  localparam int RESP_W    = 128;
  localparam int TMO_W     = 16;
  localparam int TMO_CYC   = 64;
  localparam int MAX_RETRY = 2;
  localparam int CMD_W     = 2 + IDX_W + ARG_W;
  localparam int LIM       = 4 * TMO_CYC;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_start = 1'b0;
  logic [IDX_W-1:0]  cmd_index = '0;
  logic [ARG_W-1:0]  argument_reg = '0;
  logic [1:0]        resp_type = '0;
  logic              data_read = 1'b0;
  logic              data_write = 1'b0;
  logic [RESP_W-1:0] resp_out;
  logic              idle_out;
  logic              done_out;
  logic [2:0]        err_out;
  logic              data_rd_start;
  logic              data_wr_start;

  sd_cmd_engine_if #(
    .IDX_W(IDX_W), .ARG_W(ARG_W), .RESP_W(RESP_W)
  ) phy ();

  sd_cmd_engine #(
    .IDX_W(IDX_W), .ARG_W(ARG_W), .RESP_W(RESP_W),
    .TMO_W(TMO_W), .TMO_CYC(TMO_CYC),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clock        (clk),
    .reset        (rst),
    .cmd_start    (cmd_start),
    .cmd_index    (cmd_index),
    .argument_reg (argument_reg),
    .resp_type    (resp_type),
    .data_read    (data_read),
    .data_write   (data_write),
    .phy          (phy),
    .resp_out     (resp_out),
    .idle_out     (idle_out),
    .done_out     (done_out),
    .err_out      (err_out),
    .data_rd_start(data_rd_start),
    .data_wr_start(data_wr_start)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // event counters sampled on the falling edge
  int sends = 0, dones = 0;
  int rd_all = 0, wr_all = 0, rd_dn = 0, wr_dn = 0;
  logic req_prev = 1'b0;
  logic [2:0] err_dn = '0;

  always @(negedge clk) begin
    if (phy.req_out && !req_prev) sends++;
    req_prev = phy.req_out;
    if (data_rd_start) rd_all++;
    if (data_wr_start) wr_all++;
    if (done_out) begin
      dones++;
      err_dn = err_out;
      if (data_rd_start) rd_dn++;
      if (data_wr_start) wr_dn++;
    end
  end

  // per-attempt behaviour of the serial host
  logic              att_rsp [0:MAX_RETRY];
  logic              att_crc [0:MAX_RETRY];
  logic [RESP_W-1:0] att_val [0:MAX_RETRY];

  // model outputs
  int                e_att;
  logic [2:0]        e_err;
  logic              e_ok;
  logic [RESP_W-1:0] e_resp;

  // observations from one command
  logic              o_tmo, o_req1;
  logic [CMD_W-1:0]  o_cmd;
  int                o_sends, o_dones;
  int                o_rd, o_wr, o_rd_dn, o_wr_dn;
  logic [2:0]        o_err_dn, o_err;
  logic [RESP_W-1:0] o_resp;
  logic              o_idle;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outcome of a command from the host's per-attempt behaviour.
  function automatic void model(
    input logic [IDX_W-1:0] idx,
    input logic [1:0] rt
  );
    logic [RESP_W-1:0] v;
    int cause;
    bit fin;
    e_att = 0; e_err = '0; e_ok = 1'b0;
    e_resp = '0; fin = 1'b0;
    while (!fin) begin
      cause = ERR_TMO;
      v = att_val[e_att];
      if (rt == RESP_NONE) begin
        e_ok = 1'b1; fin = 1'b1;
      end else if (!att_rsp[e_att]) begin
        cause = ERR_TMO;
      end else begin
        e_resp = v;
        if (att_crc[e_att]) begin
          cause = ERR_CRC;
        end else if (rt != RESP_LONG && idx != CMD41 &&
                     v[ARG_W +: IDX_W] != idx) begin
          e_err[ERR_IDX] = 1'b1; fin = 1'b1;
        end else begin
          e_ok = 1'b1; fin = 1'b1;
        end
      end
      e_att++;
      if (!fin && e_att > MAX_RETRY) begin
        e_err[cause] = 1'b1; fin = 1'b1;
      end
    end
  endfunction

  // Launch one command and play the serial host until done_out.
  task automatic drive(
    input logic [IDX_W-1:0] idx,
    input logic [ARG_W-1:0] arg,
    input logic [1:0] rt,
    input logic rd, input logic wr,
    input int ack_dly, input int rsp_dly
  );
    int s0, d0, r0, w0, rn0, wn0, n;
    s0 = sends; d0 = dones; r0 = rd_all;
    w0 = wr_all; rn0 = rd_dn; wn0 = wr_dn;
    o_tmo = 1'b0;
    cmd_index = idx; argument_reg = arg;
    resp_type = rt; data_read = rd;
    data_write = wr; cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    o_req1 = phy.req_out;
    o_cmd  = phy.cmd_out;
    for (int a = 0; a <= MAX_RETRY; a++) begin
      n = 0;
      while (!phy.req_out && dones == d0 && n < LIM) begin
        step(); n++;
      end
      if (dones != d0) break;
      if (n >= LIM) begin o_tmo = 1'b1; break; end
      repeat (ack_dly) step();
      phy.ack_in = 1'b1;
      n = 0;
      while (phy.req_out && n < LIM) begin step(); n++; end
      if (n >= LIM) o_tmo = 1'b1;
      phy.ack_in = 1'b0;
      if (rt != RESP_NONE && att_rsp[a]) begin
        repeat (rsp_dly) step();
        phy.cmd_in = att_val[a];
        phy.crc_err_in = att_crc[a];
        phy.req_in = 1'b1;
        n = 0;
        while (!phy.ack_out && n < LIM) begin step(); n++; end
        if (n >= LIM) o_tmo = 1'b1;
        phy.req_in = 1'b0;
        phy.crc_err_in = 1'b0;
        n = 0;
        while (phy.ack_out && n < LIM) begin step(); n++; end
        if (n >= LIM) o_tmo = 1'b1;
      end
    end
    n = 0;
    while (dones == d0 && n < LIM) begin step(); n++; end
    if (n >= LIM) o_tmo = 1'b1;
    repeat (2) step();
    o_sends = sends - s0;  o_dones = dones - d0;
    o_rd = rd_all - r0;    o_wr = wr_all - w0;
    o_rd_dn = rd_dn - rn0; o_wr_dn = wr_dn - wn0;
    o_err_dn = err_dn;     o_err = err_out;
    o_resp = resp_out;     o_idle = idle_out;
  endtask

  task automatic set_att(
    input int a, input logic r, input logic c,
    input logic [RESP_W-1:0] v
  );
    att_rsp[a] = r; att_crc[a] = c; att_val[a] = v;
  endtask

  function automatic logic [RESP_W-1:0] rsp_with(
    input logic [IDX_W-1:0] idx
  );
    logic [RESP_W-1:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    v[ARG_W +: IDX_W] = idx;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_tests++;
    if ({idle_out, phy.req_out, phy.ack_out, done_out}
        !== 4'b1000) begin
      $display("FAIL reset_ctl: got %b want 1000",
        {idle_out, phy.req_out, phy.ack_out, done_out});
      n_fail++;
    end
    n_tests++;
    if ({err_out, data_rd_start, data_wr_start} !== 5'b0) begin
      $display("FAIL reset_err: got %b want 0",
        {err_out, data_rd_start, data_wr_start});
      n_fail++;
    end
    n_tests++;
    if (resp_out !== '0 || phy.cmd_out !== '0) begin
      $display("FAIL reset_data: resp %0h cmd %0h want 0",
        resp_out, phy.cmd_out);
      n_fail++;
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_cmd0();
    set_att(0, 1'b0, 1'b0, '0);
    drive(6'd0, 32'd0, RESP_NONE, 1'b0, 1'b0, 2, 0);
    n_tests++;
    if (o_req1 !== 1'b1) begin
      $display("FAIL cmd0_req_lat: got %b want 1", o_req1);
      n_fail++;
    end
    n_tests++;
    if (o_cmd !== 40'h40_0000_0000) begin
      $display("FAIL cmd0_frame: got %h want 4000000000", o_cmd);
      n_fail++;
    end
    n_tests++;
    if (o_dones !== 1 || o_err_dn !== 3'b000 || o_tmo) begin
      $display("FAIL cmd0_done: dones %0d err %b tmo %b want 1 000 0",
        o_dones, o_err_dn, o_tmo);
      n_fail++;
    end
    n_tests++;
    if (o_rd + o_wr !== 0) begin
      $display("FAIL cmd0_data: got %0d pulses want 0", o_rd + o_wr);
      n_fail++;
    end
  endtask

  task automatic test_cmd17_read();
    logic [RESP_W-1:0] v;
    v = rsp_with(6'd17);
    set_att(0, 1'b1, 1'b0, v);
    drive(6'd17, 32'h0000_0200, RESP_SHORT, 1'b1, 1'b0, 1, 2);
    n_tests++;
    if (o_cmd !== 40'h51_0000_0200) begin
      $display("FAIL cmd17_frame: got %h want 5100000200", o_cmd);
      n_fail++;
    end
    n_tests++;
    if (o_resp !== v) begin
      $display("FAIL cmd17_resp: got %h want %h", o_resp, v);
      n_fail++;
    end
    n_tests++;
    if (o_rd_dn !== 1 || o_rd !== 1 || o_wr !== 0) begin
      $display("FAIL cmd17_rd: rd_dn %0d rd %0d wr %0d want 1 1 0",
        o_rd_dn, o_rd, o_wr);
      n_fail++;
    end
    n_tests++;
    if (o_err !== 3'b000 || o_dones !== 1) begin
      $display("FAIL cmd17_err: err %b dones %0d want 000 1",
        o_err, o_dones);
      n_fail++;
    end
  endtask

  task automatic test_cmd2_long();
    logic [RESP_W-1:0] v;
    v = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    set_att(0, 1'b1, 1'b0, v);
    drive(6'd2, 32'd0, RESP_LONG, 1'b0, 1'b0, 0, 0);
    n_tests++;
    if (o_resp !== v) begin
      $display("FAIL cmd2_resp: got %h want %h", o_resp, v);
      n_fail++;
    end
    n_tests++;
    if (o_err !== 3'b000 || o_sends !== 1) begin
      $display("FAIL cmd2_err: err %b sends %0d want 000 1",
        o_err, o_sends);
      n_fail++;
    end
  endtask

  task automatic test_no_resp_retry();
    for (int a = 0; a <= MAX_RETRY; a++)
      set_att(a, 1'b0, 1'b0, '0);
    drive(6'd8, 32'h1AA, RESP_SHORT, 1'b1, 1'b0, 0, 0);
    n_tests++;
    if (o_sends !== 3) begin
      $display("FAIL noresp_sends: got %0d want 3", o_sends);
      n_fail++;
    end
    n_tests++;
    if (o_err_dn !== 3'b001 || o_dones !== 1 || o_rd !== 0) begin
      $display("FAIL noresp_err: err %b dones %0d rd %0d want 001 1 0",
        o_err_dn, o_dones, o_rd);
      n_fail++;
    end
  endtask

  task automatic test_crc_retry();
    set_att(0, 1'b1, 1'b1, rsp_with(6'd13));
    set_att(1, 1'b1, 1'b0, rsp_with(6'd13));
    drive(6'd13, 32'h55, RESP_BUSY, 1'b0, 1'b1, 1, 1);
    n_tests++;
    if (o_sends !== 2 || o_err !== 3'b000) begin
      $display("FAIL crc_retry: sends %0d err %b want 2 000",
        o_sends, o_err);
      n_fail++;
    end
    n_tests++;
    if (o_wr_dn !== 1 || o_resp !== att_val[1]) begin
      $display("FAIL crc_retry_out: wr %0d resp %h want 1 %h",
        o_wr_dn, o_resp, att_val[1]);
      n_fail++;
    end
  endtask

  task automatic test_index_err();
    set_att(0, 1'b1, 1'b0, rsp_with(6'd5));
    drive(6'd8, 32'h1AA, RESP_SHORT, 1'b1, 1'b0, 0, 0);
    n_tests++;
    if (o_err_dn !== 3'b010 || o_rd !== 0 || o_sends !== 1) begin
      $display("FAIL index_err: err %b rd %0d sends %0d want 010 0 1",
        o_err_dn, o_rd, o_sends);
      n_fail++;
    end
  endtask

  task automatic test_send_timeout();
    int n, s0;
    s0 = sends;
    cmd_index = 6'd9; resp_type = RESP_SHORT;
    data_read = 1'b0; data_write = 1'b0;
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    n = 0;
    while (!done_out && n < LIM) begin step(); n++; end
    n_tests++;
    if (n !== TMO_CYC || err_out !== 3'b001) begin
      $display("FAIL send_tmo: cycles %0d err %b want %0d 001",
        n, err_out, TMO_CYC);
      n_fail++;
    end
    repeat (2) step();
    n_tests++;
    if (sends - s0 !== 1 || idle_out !== 1'b1) begin
      $display("FAIL send_tmo_end: sends %0d idle %b want 1 1",
        sends - s0, idle_out);
      n_fail++;
    end
  endtask

  task automatic test_ack_early();
    int n, d0;
    d0 = dones;
    phy.ack_in = 1'b1;
    cmd_index = 6'd0; resp_type = RESP_NONE;
    data_read = 1'b1; data_write = 1'b1;
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    step();
    phy.ack_in = 1'b0;
    n = 0;
    while (dones == d0 && n < LIM) begin step(); n++; end
    n_tests++;
    if (dones - d0 !== 1 || err_dn !== 3'b000 || n >= LIM) begin
      $display("FAIL ack_early: dones %0d err %b want 1 000",
        dones - d0, err_dn);
      n_fail++;
    end
  endtask

  task automatic test_both_data();
    set_att(0, 1'b1, 1'b0, rsp_with(6'd41) ^ {RESP_W{1'b0}});
    att_val[0][ARG_W +: IDX_W] = 6'd63;
    drive(6'd41, 32'h40FF_8000, RESP_SHORT, 1'b1, 1'b1, 0, 1);
    n_tests++;
    if (o_rd_dn !== 1 || o_wr_dn !== 1 || o_err !== 3'b000) begin
      $display("FAIL both_data: rd %0d wr %0d err %b want 1 1 000",
        o_rd_dn, o_wr_dn, o_err);
      n_fail++;
    end
  endtask

  task automatic test_req_ignored();
    logic seen;
    seen = 1'b0;
    phy.cmd_in = '1;
    phy.req_in = 1'b1;
    repeat (4) begin
      step();
      seen = seen | phy.ack_out | ~idle_out;
    end
    phy.req_in = 1'b0;
    step();
    n_tests++;
    if (seen !== 1'b0 || resp_out === '1) begin
      $display("FAIL req_ignored: ack/busy %b resp %h want 0",
        seen, resp_out);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    cmd_index = 6'd55; resp_type = RESP_SHORT;
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    phy.ack_in = 1'b1;
    n = 0;
    while (phy.req_out && n < LIM) begin step(); n++; end
    phy.ack_in = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    n_tests++;
    if ({idle_out, phy.req_out, phy.ack_out} !== 3'b100) begin
      $display("FAIL reset_mid: idle/req/ack %b want 100",
        {idle_out, phy.req_out, phy.ack_out});
      n_fail++;
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [IDX_W-1:0] idx;
    logic [ARG_W-1:0] arg;
    logic [1:0] rt;
    logic rd, wr;
    for (int it = 0; it < 25; it++) begin
      idx = ($urandom_range(0, 5) == 0) ? IDX_W'(CMD41)
                                         : IDX_W'($urandom);
      arg = $urandom;
      rt  = 2'($urandom_range(0, 3));
      rd  = 1'($urandom); wr = 1'($urandom);
      for (int a = 0; a <= MAX_RETRY; a++) begin
        att_rsp[a] = ($urandom_range(0, 7) != 0);
        att_crc[a] = ($urandom_range(0, 3) == 0);
        att_val[a] = rsp_with(idx);
        if ($urandom_range(0, 4) == 0)
          att_val[a][ARG_W +: IDX_W] = IDX_W'($urandom);
      end
      model(idx, rt);
      drive(idx, arg, rt, rd, wr,
        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      n_tests++;
      if (o_tmo !== 1'b0 || o_dones !== 1) begin
        $display("FAIL rnd%0d_done: tmo %b dones %0d want 0 1",
          it, o_tmo, o_dones);
        n_fail++;
      end
      n_tests++;
      if (o_cmd !== {2'b01, idx, arg}) begin
        $display("FAIL rnd%0d_frame: got %h want %h",
          it, o_cmd, {2'b01, idx, arg});
        n_fail++;
      end
      n_tests++;
      if (o_sends !== e_att) begin
        $display("FAIL rnd%0d_sends: got %0d want %0d",
          it, o_sends, e_att);
        n_fail++;
      end
      n_tests++;
      if (o_err_dn !== e_err || o_err !== e_err) begin
        $display("FAIL rnd%0d_err: got %b/%b want %b",
          it, o_err_dn, o_err, e_err);
        n_fail++;
      end
      n_tests++;
      if (o_rd_dn !== int'(e_ok && rd) || o_rd !== o_rd_dn ||
          o_wr_dn !== int'(e_ok && wr) || o_wr !== o_wr_dn) begin
        $display("FAIL rnd%0d_data: rd %0d wr %0d want %0d %0d",
          it, o_rd, o_wr, e_ok && rd, e_ok && wr);
        n_fail++;
      end
      n_tests++;
      if (o_resp !== e_resp || o_idle !== 1'b1) begin
        $display("FAIL rnd%0d_resp: got %h idle %b want %h 1",
          it, o_resp, o_idle, e_resp);
        n_fail++;
      end
    end
  endtask

  initial begin
    phy.ack_in = 1'b0;
    phy.req_in = 1'b0;
    phy.cmd_in = '0;
    phy.crc_err_in = 1'b0;
    test_reset();
    test_cmd0();
    test_cmd17_read();
    test_cmd2_long();
    test_no_resp_retry();
    test_crc_retry();
    test_index_err();
    test_send_timeout();
    test_ack_early();
    test_both_data();
    test_req_ignored();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: sim time limit reached, %0d of %0d failed",
      n_fail, n_tests);
    $fatal(1, "watchdog");
  end

endmodule
